pixel_readout: RTL
==================

Name: pixel_readout

Overview:
- Downstream consumer of the pixel array/controller pair; captures the four 8-bit pixel buses during the read12/read34 phases.
- Assembles one 4-pixel frame and streams it out one byte per transfer over a valid/ready interface.
- Double-buffered, so the controller's next exposure can overlap draining of the previous frame.
- Flags dropped frames and read-sequence protocol errors.

Parameters:
- DATA_W, 8, width of each pixel bus and of out_data.
- CNT_W, 8, width of the frame counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- read12  input  1  controller strobe: pixels 1 and 2 driving pixData1/2.
- read34  input  1  controller strobe: pixels 3 and 4 driving pixData3/4.
- pixData1..pixData4  input  DATA_W each  pixel buses, sampled as inputs only.
- out_data  output  DATA_W  current pixel byte.
- out_index  output  2  pixel number minus 1 (0..3) of out_data.
- out_valid  output  1  out_data/out_index/out_sof/out_eof valid.
- out_ready  input  1  sink accepts when out_valid & out_ready.
- out_sof  output  1  high with index 0.
- out_eof  output  1  high with index 3.
- frame_count  output  CNT_W  frames committed to the output buffer.
- overflow  output  1  sticky: a complete frame was dropped.
- proto_err  output  1  sticky: illegal strobe sequence seen.

Behaviour:
- Reset (synchronous, active-high) clears all registers. All outputs are 0 after reset: out_valid, out_data, out_index, out_sof, out_eof, frame_count, overflow and proto_err. Reset mid-frame discards both capture and output buffers.
- Edge detection uses registered copies r12_q and r34_q. A fall is strobe_q=1 & strobe=0.
- Capture: while read12=1, latch cap1<=pixData1 and cap2<=pixData2 every cycle, so the last high cycle wins. Same rule applies to read34 with cap3/cap4.
- Capture FSM has two states:
  - WAIT12: a read12 fall moves to WAIT34.
  - WAIT34: a read34 fall raises frame_done for one cycle and moves back to WAIT12.
  - A read12 fall while in WAIT34 restarts the frame, recapturing 1/2, and stays in WAIT34. No error is flagged.
- Protocol errors:
  - read34 high while in WAIT12 sets proto_err and is not captured.
  - read12 and read34 high in the same cycle sets proto_err. Neither is captured that cycle, and the state is unchanged.
- Commit: on frame_done, if the output FSM is IDLE, or is in SEND with the index-3 byte being accepted that same cycle:
  - copy cap1..cap4 to obuf0..3;
  - increment frame_count (wrapping);
  - out_valid=1 with index 0 in the next cycle, with no bubble between back-to-back frames.
  - Otherwise the frame is dropped, overflow<=1, and frame_count is unchanged.
- Latency: read34 falls at cycle N (first low cycle); frame_done is at N+1; out_valid rises at N+2.
- Output FSM has two states:
  - IDLE: out_valid=0.
  - SEND: out_valid=1, out_data=obuf[idx], out_index=idx, out_sof=(idx==0), out_eof=(idx==3).
  - On accept, idx increments. An accept at idx 3 returns to IDLE, or reloads from a simultaneous commit.
- Handshake rules:
  - Outputs are held stable while out_valid & !out_ready.
  - out_valid never drops without an accept, except on reset.
  - out_ready while IDLE is ignored.
- Sticky flags clear only on reset.

Decomposition:
- Package pixel_pkg holds:
  - DATA_W, NPIX=4;
  - the capture state enum {WAIT12, WAIT34};
  - the output state enum {IDLE, SEND}.
- One sub-module, pixel_capture: edge detectors, capture registers, capture FSM and proto_err; produces cap1..4 and frame_done.
- The top level holds the output buffer, output FSM, frame_count and overflow.

Test Plan:
- Single frame: read12 high 3 cycles with pixData1/2=0x11/0x22, then read34 high 2 cycles with 0x33/0x44, out_ready=1 -> bytes 11,22,33,44 on four consecutive cycles. out_sof is on 11, out_eof is on 44, out_valid rises 2 cycles after the read34 fall, frame_count=1.
- Backpressure: as above with out_ready=0 for 5 cycles, then toggling 1,0,1,1,1 -> out_data is held at 0x11 during the stall, and all four bytes appear in order with no duplicates or skips.
- Overflow: out_ready=0 after frame A (0xA0..A3) commits; a full frame B completes -> overflow=1, frame_count stays 1. Releasing out_ready yields A0..A3 only.
- Back-to-back: frame B's read34 fall is timed so frame_done coincides with the accept of A3 -> B0 appears on the next cycle with no gap, overflow=0, frame_count=2.
- Protocol error: read34 pulse with no prior read12 -> proto_err=1 and no output. Read12 and read34 high in the same cycle -> proto_err stays 1. A following legal frame 0x01..04 is still delivered correctly.
- Reset mid-operation: assert reset while in SEND at idx 2 -> next cycle all outputs are 0. A new frame 0x55,0x66,0x77,0x88 streams normally with frame_count=1.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared widths and state encodings for the pixel readout block and its capture front end.
package pixel_pkg;
   localparam int DATA_W = 8;
   localparam int NPIX   = 4;

   typedef enum logic {WAIT12 = 1'b0, WAIT34 = 1'b1} cap_state_e;
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} out_state_e;
endpackage

// File: rtl/pixel_readout_if.sv
// Byte-stream output of the pixel readout: one pixel per transfer with index and frame markers.
interface pixel_readout_if #(
   parameter int DATA_W = pixel_pkg::DATA_W
) ();
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_index;
   logic              out_valid;
   logic              out_ready;
   logic              out_sof;
   logic              out_eof;

   // A byte transfers on a rising clk edge where out_valid & out_ready. Once out_valid is
   // raised it stays high, with data/index/sof/eof stable, until that transfer happens.
   modport master (output out_data, out_index, out_valid, out_sof, out_eof, input out_ready);
   modport slave  (input out_data, out_index, out_valid, out_sof, out_eof, output out_ready);
endinterface

// File: rtl/pixel_capture.sv
// Watches the read12/read34 strobes, latches the pixel buses and signals a completed frame.
module pixel_capture
   import pixel_pkg::*;
#(
   parameter int DATA_W = pixel_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read12,
   input  logic              read34,
   input  logic [DATA_W-1:0] pix_data1,
   input  logic [DATA_W-1:0] pix_data2,
   input  logic [DATA_W-1:0] pix_data3,
   input  logic [DATA_W-1:0] pix_data4,
   output logic [DATA_W-1:0] cap1,
   output logic [DATA_W-1:0] cap2,
   output logic [DATA_W-1:0] cap3,
   output logic [DATA_W-1:0] cap4,
   output logic              frame_done,
   output logic              proto_err,
   output cap_state_e        state
);
   cap_state_e        state_q, state_d;
   logic              r12_q, r34_q;
   logic              frame_done_q, frame_done_d;
   logic              proto_err_q, proto_err_d;
   logic [DATA_W-1:0] cap1_q, cap1_d, cap2_q, cap2_d, cap3_q, cap3_d, cap4_q, cap4_d;
   logic              fall12, fall34, both, in_34;

   always_comb begin
      fall12       = r12_q & ~read12;
      fall34       = r34_q & ~read34;
      both         = read12 & read34;
      // read34 may follow read12 back to back: the read12 fall cycle already counts as WAIT34.
      in_34        = (state_q == WAIT34) | fall12;
      state_d      = state_q;
      cap1_d       = cap1_q;
      cap2_d       = cap2_q;
      cap3_d       = cap3_q;
      cap4_d       = cap4_q;
      frame_done_d = 1'b0;
      proto_err_d  = proto_err_q;

      if (both) begin
         proto_err_d = 1'b1;
      end else begin
         if (read12) begin
            cap1_d = pix_data1;
            cap2_d = pix_data2;
         end
         if (read34) begin
            if (in_34) begin
               cap3_d = pix_data3;
               cap4_d = pix_data4;
            end else begin
               proto_err_d = 1'b1;
            end
         end
      end

      if (fall12) begin
         state_d = WAIT34;
      end else if ((state_q == WAIT34) && fall34) begin
         frame_done_d = 1'b1;
         state_d      = WAIT12;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT12;
         r12_q        <= 1'b0;
         r34_q        <= 1'b0;
         frame_done_q <= 1'b0;
         proto_err_q  <= 1'b0;
         cap1_q       <= '0;
         cap2_q       <= '0;
         cap3_q       <= '0;
         cap4_q       <= '0;
      end else begin
         state_q      <= state_d;
         r12_q        <= read12;
         r34_q        <= read34;
         frame_done_q <= frame_done_d;
         proto_err_q  <= proto_err_d;
         cap1_q       <= cap1_d;
         cap2_q       <= cap2_d;
         cap3_q       <= cap3_d;
         cap4_q       <= cap4_d;
      end
   end

   assign cap1       = cap1_q;
   assign cap2       = cap2_q;
   assign cap3       = cap3_q;
   assign cap4       = cap4_q;
   assign frame_done = frame_done_q;
   assign proto_err  = proto_err_q;
   assign state      = state_q;
endmodule

// File: rtl/pixel_readout.sv
// Pixel readout top: commits captured frames into an output buffer and streams them byte by byte.
module pixel_readout
   import pixel_pkg::*;
#(
   parameter int DATA_W = pixel_pkg::DATA_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read12,
   input  logic              read34,
   input  logic [DATA_W-1:0] pixData1,
   input  logic [DATA_W-1:0] pixData2,
   input  logic [DATA_W-1:0] pixData3,
   input  logic [DATA_W-1:0] pixData4,
   pixel_readout_if.master   out_if,
   output logic [CNT_W-1:0]  frame_count,
   output logic              overflow,
   output logic              proto_err,
   output cap_state_e        dbg_cap_state,
   output out_state_e        dbg_out_state
);
   logic [DATA_W-1:0] cap1, cap2, cap3, cap4;
   logic              frame_done;

   pixel_capture #(.DATA_W(DATA_W)) u_capture (
      .clk        (clk),
      .reset      (reset),
      .read12     (read12),
      .read34     (read34),
      .pix_data1  (pixData1),
      .pix_data2  (pixData2),
      .pix_data3  (pixData3),
      .pix_data4  (pixData4),
      .cap1       (cap1),
      .cap2       (cap2),
      .cap3       (cap3),
      .cap4       (cap4),
      .frame_done (frame_done),
      .proto_err  (proto_err),
      .state      (dbg_cap_state)
   );

   out_state_e        state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-1:0] obuf_q [NPIX];
   logic [DATA_W-1:0] obuf_d [NPIX];
   logic [CNT_W-1:0]  frame_count_q, frame_count_d;
   logic              overflow_q, overflow_d;
   logic              send, accept, last_accept, commit;

   always_comb begin
      send          = (state_q == SEND);
      accept        = send & out_if.out_ready;
      last_accept   = accept & (idx_q == 2'd3);
      // The buffer is free when idle, or when its last byte leaves this very cycle.
      commit        = frame_done & (~send | last_accept);
      state_d       = state_q;
      idx_d         = idx_q;
      obuf_d        = obuf_q;
      frame_count_d = frame_count_q;
      overflow_d    = overflow_q | (frame_done & ~commit);

      if (commit) begin
         obuf_d[0]     = cap1;
         obuf_d[1]     = cap2;
         obuf_d[2]     = cap3;
         obuf_d[3]     = cap4;
         idx_d         = 2'd0;
         state_d       = SEND;
         frame_count_d = frame_count_q + 1'b1;
      end else if (accept) begin
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         idx_q         <= 2'd0;
         obuf_q        <= '{default: '0};
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         obuf_q        <= obuf_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
      end
   end

   assign out_if.out_valid = send;
   assign out_if.out_data  = send ? obuf_q[idx_q] : '0;
   assign out_if.out_index = send ? idx_q : 2'd0;
   assign out_if.out_sof   = send & (idx_q == 2'd0);
   assign out_if.out_eof   = send & (idx_q == 2'd3);
   assign frame_count      = frame_count_q;
   assign overflow         = overflow_q;
   assign dbg_out_state    = state_q;
endmodule
